// File: rtl/ads1115_pkg.sv
// Shared constants and types for the ADS1115 blocks that talk to CoreI2C over APB.
package ads1115_pkg;

    // CoreI2C register map
    localparam logic [8:0] ADDR_CTRL = 9'h000;
    localparam logic [8:0] ADDR_STAT = 9'h004;
    localparam logic [8:0] ADDR_DATA = 9'h008;

    // CTRL command bytes
    localparam logic [7:0] CMD_START  = 8'hE0;
    localparam logic [7:0] CMD_CLR    = 8'hC0;
    localparam logic [7:0] CMD_CLR_AA = 8'hC4;
    localparam logic [7:0] CMD_STOP   = 8'hD0;

    // STAT codes
    localparam logic [7:0] STAT_START     = 8'h08;
    localparam logic [7:0] STAT_RSTART    = 8'h10;
    localparam logic [7:0] STAT_SLAW_ACK  = 8'h18;
    localparam logic [7:0] STAT_SLAW_NACK = 8'h20;
    localparam logic [7:0] STAT_TXD_ACK   = 8'h28;
    localparam logic [7:0] STAT_TXD_NACK  = 8'h30;
    localparam logic [7:0] STAT_SLAR_ACK  = 8'h40;
    localparam logic [7:0] STAT_SLAR_NACK = 8'h48;
    localparam logic [7:0] STAT_RXD_ACK   = 8'h50;
    localparam logic [7:0] STAT_RXD_NACK  = 8'h58;
    localparam logic [7:0] STAT_IDLE      = 8'hF8;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StSlaw,
        StPtr,
        StRstart,
        StSlar,
        StRdMsb,
        StRdLsb,
        StStop,
        StDone,
        StAbort
    } state_t;

    // Transfer within a step: optional DATA write, CTRL write, STAT poll, optional DATA read
    typedef enum logic [1:0] {
        PhData,
        PhCtrl,
        PhPoll,
        PhRead
    } phase_t;

    // STAT value that lets a step proceed
    function automatic logic [7:0] expected_stat(state_t s);
        case (s)
            StStart:  return STAT_START;
            StSlaw:   return STAT_SLAW_ACK;
            StPtr:    return STAT_TXD_ACK;
            StRstart: return STAT_RSTART;
            StSlar:   return STAT_SLAR_ACK;
            StRdMsb:  return STAT_RXD_ACK;
            StRdLsb:  return STAT_RXD_NACK;
            default:  return STAT_IDLE;
        endcase
    endfunction

    function automatic state_t next_state(state_t s);
        case (s)
            StStart:  return StSlaw;
            StSlaw:   return StPtr;
            StPtr:    return StRstart;
            StRstart: return StSlar;
            StSlar:   return StRdMsb;
            StRdMsb:  return StRdLsb;
            StRdLsb:  return StStop;
            StStop:   return StDone;
            default:  return StIdle;
        endcase
    endfunction

    // Steps that load DATA before kicking CTRL
    function automatic phase_t first_phase(state_t s);
        case (s)
            StSlaw, StPtr, StSlar: return PhData;
            default:               return PhCtrl;
        endcase
    endfunction

    function automatic logic [7:0] ctrl_cmd(state_t s);
        case (s)
            StStart, StRstart: return CMD_START;
            StRdMsb:           return CMD_CLR_AA;
            StStop, StAbort:   return CMD_STOP;
            default:           return CMD_CLR;
        endcase
    endfunction

endpackage

// File: rtl/ads1115_apb_engine.sv
// Single APB master transfer: setup, access (stretched by pready), one idle gap cycle.
module ads1115_apb_engine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [8:0] addr,
    input  logic [7:0] wdata,
    input  logic       wr,
    input  logic [7:0] prdata,
    input  logic       pready,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic [8:0] paddr,
    output logic [7:0] pwdata,
    output logic       pwrite,
    output logic       psel,
    output logic       penable
);

    typedef enum logic [1:0] {EngIdle, EngSetup, EngAccess, EngGap} eng_state_t;

    eng_state_t ph_q, ph_d;
    logic [8:0] paddr_q;
    logic [7:0] pwdata_q;
    logic       pwrite_q;

    // Phase register and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q     <= EngIdle;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            ph_q <= ph_d;
            if (req && ready) begin
                paddr_q  <= addr;
                pwdata_q <= wdata;
                pwrite_q <= wr;
            end
        end
    end

    // Next phase; a new request may start from the gap cycle so the gap is exactly one cycle
    always_comb begin
        ph_d = ph_q;
        unique case (ph_q)
            EngIdle,
            EngGap:    ph_d = req ? EngSetup : EngIdle;
            EngSetup:  ph_d = EngAccess;
            EngAccess: ph_d = pready ? EngGap : EngAccess;
        endcase
    end

    assign ready   = (ph_q == EngIdle) || (ph_q == EngGap);
    assign done    = (ph_q == EngAccess) && pready;
    assign rdata   = prdata;
    assign psel    = (ph_q == EngSetup) || (ph_q == EngAccess);
    assign penable = (ph_q == EngAccess);
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;

endmodule

// File: rtl/ads1115_conv_reader.sv
// Reads the ADS1115 conversion register through CoreI2C and presents the 16-bit sample.
module ads1115_conv_reader
    import ads1115_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR   = 7'h48,
    parameter logic [15:0] POLL_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  prdata,
    input  logic        pready,
    output logic [8:0]  paddr,
    output logic [7:0]  pwdata,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        error,
    output logic [7:0]  err_code
);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]  msb_q, msb_d, lsb_q, lsb_d;
    logic [15:0] result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic [7:0]  err_code_q, err_code_d;
    logic [7:0]  abort_code_q, abort_code_d;

    logic        eng_req, eng_ready, eng_done;
    logic [8:0]  xfer_addr;
    logic [7:0]  xfer_wdata, eng_rdata;
    logic        xfer_wr;

    function automatic logic [7:0] data_byte(state_t s);
        case (s)
            StSlaw:  return {SLAVE_ADDR, 1'b0};
            StSlar:  return {SLAVE_ADDR, 1'b1};
            default: return 8'h00;
        endcase
    endfunction

    ads1115_apb_engine u_apb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eng_req),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .wr      (xfer_wr),
        .prdata  (prdata),
        .pready  (pready),
        .ready   (eng_ready),
        .done    (eng_done),
        .rdata   (eng_rdata),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            phase_q        <= PhCtrl;
            cnt_q          <= '0;
            msb_q          <= '0;
            lsb_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= '0;
            abort_code_q   <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            msb_q          <= msb_d;
            lsb_q          <= lsb_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
            abort_code_q   <= abort_code_d;
        end
    end

    // Transfer descriptor, sequencing and output next-state
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        msb_d          = msb_q;
        lsb_d          = lsb_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        busy_d         = busy_q;
        error_d        = 1'b0;
        err_code_d     = err_code_q;
        abort_code_d   = abort_code_q;
        cnt_inc        = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        xfer_addr  = ADDR_STAT;
        xfer_wdata = 8'h00;
        xfer_wr    = 1'b0;
        unique case (phase_q)
            PhData: begin
                xfer_addr  = ADDR_DATA;
                xfer_wdata = data_byte(state_q);
                xfer_wr    = 1'b1;
            end
            PhCtrl: begin
                xfer_addr  = ADDR_CTRL;
                xfer_wdata = ctrl_cmd(state_q);
                xfer_wr    = 1'b1;
            end
            PhPoll: xfer_addr = ADDR_STAT;
            PhRead: xfer_addr = ADDR_DATA;
        endcase

        eng_req = (state_q != StIdle) && (state_q != StDone) && eng_ready;

        case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d  = 1'b1;
                    state_d = StStart;
                    phase_d = first_phase(StStart);
                    cnt_d   = '0;
                end
            end
            StDone: begin
                result_d       = {msb_q, lsb_q};
                result_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = StIdle;
            end
            default: begin
                if (eng_done) begin
                    unique case (phase_q)
                        PhData: phase_d = PhCtrl;
                        PhCtrl: begin
                            if (state_q == StStop) begin
                                state_d = StDone;
                            end else if (state_q == StAbort) begin
                                state_d    = StIdle;
                                error_d    = 1'b1;
                                err_code_d = abort_code_q;
                                busy_d     = 1'b0;
                            end else begin
                                phase_d = PhPoll;
                            end
                        end
                        PhPoll: begin
                            if (eng_rdata == STAT_IDLE) begin
                                cnt_d = cnt_inc;
                                if (cnt_inc >= POLL_TIMEOUT) begin
                                    state_d      = StAbort;
                                    phase_d      = PhCtrl;
                                    abort_code_d = 8'hFF;
                                    cnt_d        = '0;
                                end
                            end else if (eng_rdata == expected_stat(state_q)) begin
                                cnt_d = '0;
                                if (state_q == StRdMsb || state_q == StRdLsb) begin
                                    phase_d = PhRead;
                                end else begin
                                    state_d = next_state(state_q);
                                    phase_d = first_phase(next_state(state_q));
                                end
                            end else begin
                                state_d      = StAbort;
                                phase_d      = PhCtrl;
                                abort_code_d = eng_rdata;
                                cnt_d        = '0;
                            end
                        end
                        PhRead: begin
                            if (state_q == StRdMsb) begin
                                msb_d = eng_rdata;
                            end else begin
                                lsb_d = eng_rdata;
                            end
                            state_d = next_state(state_q);
                            phase_d = first_phase(next_state(state_q));
                        end
                    endcase
                end
            end
        endcase
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_ads1115_conv_reader.sv
// Scoreboard bench: CoreI2C APB model plus event monitor for ads1115_conv_reader.
module tb_ads1115_conv_reader;

    localparam logic [8:0] A_CTRL = 9'h000;
    localparam logic [8:0] A_STAT = 9'h004;
    localparam logic [8:0] A_DATA = 9'h008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  prdata = 8'h00;
    logic        pready = 1'b0;
    logic [8:0]  paddr;
    logic [7:0]  pwdata;
    logic        pwrite, psel, penable;
    logic [15:0] result;
    logic        result_valid, busy, error;
    logic [7:0]  err_code;

    ads1115_conv_reader #(
        .SLAVE_ADDR   (7'h48),
        .POLL_TIMEOUT (16'd8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .prdata       (prdata),
        .pready       (pready),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pwrite       (pwrite),
        .psel         (psel),
        .penable      (penable),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        logic       wr;
        logic [7:0] data;
    } xfer_t;

    typedef struct {
        logic        is_err;
        logic [15:0] res;
        logic [7:0]  code;
    } evt_t;

    xfer_t      exp_xfer[$];
    evt_t       exp_evt[$];
    logic [7:0] stat_q[$];
    logic [7:0] data_q[$];

    int total = 0;
    int bad = 0;
    int wait_states = 0;
    int stat_reads = 0;
    int model_wcnt = 0;
    int pen_run = 0;
    int gap_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // CoreI2C model: drives pready/prdata and checks every completed transfer
    initial begin : model
        xfer_t x;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (model_wcnt < wait_states) begin
                    pready = 1'b0;
                    model_wcnt++;
                end else begin
                    pready = 1'b1;
                    if (exp_xfer.size() == 0) begin
                        fail_now("unexpected_xfer");
                    end else begin
                        x = exp_xfer.pop_front();
                        chk("xfer_addr", 32'(paddr), 32'(x.addr));
                        chk("xfer_dir", 32'(pwrite), 32'(x.wr));
                        if (x.wr) chk("xfer_wdata", 32'(pwdata), 32'(x.data));
                    end
                    if (!pwrite) begin
                        if (paddr == A_STAT) begin
                            stat_reads++;
                            prdata = (stat_q.size() != 0) ? stat_q.pop_front() : 8'hF8;
                        end else begin
                            prdata = (data_q.size() != 0) ? data_q.pop_front() : 8'h00;
                        end
                    end
                end
            end else begin
                pready = 1'b0;
                model_wcnt = 0;
            end
        end
    end

    // Monitor: result/error events against the scoreboard, plus APB shape
    initial begin : monitor
        evt_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pen_run = 0;
                gap_run = 0;
            end else begin
                if (result_valid || error) begin
                    if (exp_evt.size() == 0) begin
                        fail_now("unexpected_event");
                    end else begin
                        e = exp_evt.pop_front();
                        chk("evt_is_error", 32'(error), 32'(e.is_err));
                        chk("evt_result_valid", 32'(result_valid), 32'(!e.is_err));
                        chk("evt_result", 32'(result), 32'(e.res));
                        if (e.is_err) chk("evt_err_code", 32'(err_code), 32'(e.code));
                        chk("evt_busy_low", 32'(busy), 32'd0);
                    end
                end
                if (penable) begin
                    pen_run++;
                end else if (pen_run != 0) begin
                    chk("penable_len", 32'(pen_run), 32'(wait_states + 1));
                    pen_run = 0;
                end
                if (!busy) begin
                    gap_run = 0;
                end else if (!psel) begin
                    gap_run++;
                end else if (!penable) begin
                    chk("idle_gap", 32'(gap_run), 32'd1);
                    gap_run = 0;
                end
            end
        end
    end

    task automatic w(input logic [8:0] a, input logic [7:0] d);
        xfer_t x;
        x.addr = a;
        x.wr   = 1'b1;
        x.data = d;
        exp_xfer.push_back(x);
    endtask

    task automatic r(input logic [8:0] a);
        xfer_t x;
        x.addr = a;
        x.wr   = 1'b0;
        x.data = 8'h00;
        exp_xfer.push_back(x);
    endtask

    task automatic poll(input int n_idle, input logic [7:0] code);
        for (int i = 0; i < n_idle; i++) begin
            stat_q.push_back(8'hF8);
            r(A_STAT);
        end
        stat_q.push_back(code);
        r(A_STAT);
    endtask

    task automatic expect_evt(input logic is_err, input logic [15:0] res, input logic [7:0] code);
        evt_t e;
        e.is_err = is_err;
        e.res    = res;
        e.code   = code;
        exp_evt.push_back(e);
    endtask

    // Full read; the idle polls add up past the timeout, so the counter must clear per step
    task automatic script_happy(input logic [7:0] msb, input logic [7:0] lsb);
        w(A_CTRL, 8'hE0); poll(3, 8'h08);
        w(A_DATA, 8'h90); w(A_CTRL, 8'hC0); poll(2, 8'h18);
        w(A_DATA, 8'h00); w(A_CTRL, 8'hC0); poll(2, 8'h28);
        w(A_CTRL, 8'hE0); poll(3, 8'h10);
        w(A_DATA, 8'h91); w(A_CTRL, 8'hC0); poll(0, 8'h40);
        w(A_CTRL, 8'hC4); poll(2, 8'h50); r(A_DATA); data_q.push_back(msb);
        w(A_CTRL, 8'hC0); poll(0, 8'h58); r(A_DATA); data_q.push_back(lsb);
        w(A_CTRL, 8'hD0);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now("busy_timeout");
        @(negedge clk);
        @(negedge clk);
        chk("xfers_left", 32'(exp_xfer.size()), 32'd0);
        chk("events_left", 32'(exp_evt.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_psel"}, 32'(psel), 32'd0);
        chk({tag, "_penable"}, 32'(penable), 32'd0);
        chk({tag, "_paddr"}, 32'(paddr), 32'd0);
        chk({tag, "_pwdata"}, 32'(pwdata), 32'd0);
        chk({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        logic found;

        // Reset with start held high: must be ignored
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Happy path
        script_happy(8'h12, 8'h34);
        expect_evt(1'b0, 16'h1234, 8'h00);
        pulse_start();
        wait_idle(2000);

        // SLA+W NACK
        w(A_CTRL, 8'hE0); poll(0, 8'h08);
        w(A_DATA, 8'h90); w(A_CTRL, 8'hC0); poll(1, 8'h20);
        w(A_CTRL, 8'hD0);
        expect_evt(1'b1, 16'h1234, 8'h20);
        pulse_start();
        wait_idle(2000);

        // Timeout: STAT stuck at 0xF8 after START
        stat_reads = 0;
        w(A_CTRL, 8'hE0);
        for (int i = 0; i < 8; i++) r(A_STAT);
        w(A_CTRL, 8'hD0);
        expect_evt(1'b1, 16'h1234, 8'hFF);
        pulse_start();
        wait_idle(2000);
        chk("timeout_stat_reads", 32'(stat_reads), 32'd8);

        // Wait states on every access
        wait_states = 3;
        script_happy(8'hAB, 8'hCD);
        expect_evt(1'b0, 16'hABCD, 8'h00);
        pulse_start();
        wait_idle(4000);
        wait_states = 0;

        // start held through the transaction, including the DONE cycle
        script_happy(8'h5A, 8'hA5);
        expect_evt(1'b0, 16'h5AA5, 8'h00);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            start = 1'b1;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_idle(2000);
        repeat (10) @(negedge clk);
        chk("no_restart_busy", 32'(busy), 32'd0);
        chk("no_restart_psel", 32'(psel), 32'd0);

        // Reset during the MSB read step
        script_happy(8'h77, 8'h88);
        pulse_start();
        found = 1'b0;
        n = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            found = psel && pwrite && (paddr == A_CTRL) && (pwdata == 8'hC4);
        end
        if (!found) fail_now("rd_msb_not_reached");
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_xfer.delete();
        stat_q.delete();
        data_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        script_happy(8'h0F, 8'hF0);
        expect_evt(1'b0, 16'h0FF0, 8'h00);
        pulse_start();
        wait_idle(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
